// File: rtl/mant_sub_serial_pkg.sv
// -----------------------------------------------------------------------------
// mant_sub_serial_pkg
//   Shared definitions for the byte-serial mantissa subtractor.
//   - state_t : FSM state encoding (IDLE, SUB, NEG, DONE)
//   - SLICE_W : width of one CLA slice in bits
//   - SLICE_SH: log2(SLICE_W), used to turn a slice index into a bit offset
// -----------------------------------------------------------------------------
package mant_sub_serial_pkg;

    localparam int SLICE_W  = 8;
    localparam int SLICE_SH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mant_sub_serial_cla8.sv
// -----------------------------------------------------------------------------
// mant_sub_serial_cla8
//   8-bit carry-lookahead slice (the CLA8bit slice of the mantissa datapath).
//   Computes {o_cout, o_sum} = i_a + i_b + i_cin.
// Ports
//   i_a, i_b  in  8  operands
//   i_cin     in  1  carry in
//   o_sum     out 8  sum
//   o_cout    out 1  carry out
// -----------------------------------------------------------------------------
module mant_sub_serial_cla8
    import mant_sub_serial_pkg::*;
(
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_cin,
    output logic [SLICE_W-1:0] o_sum,
    output logic               o_cout
);

    logic [SLICE_W-1:0] w_g;
    logic [SLICE_W-1:0] w_p;
    logic [SLICE_W:0]   w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Carry recurrence c[i+1] = g[i] | p[i]&c[i]; written as a loop, it
    // flattens into the usual lookahead sum-of-products.
    always_comb begin
        w_c    = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < SLICE_W; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
    end

    assign o_sum  = w_p ^ w_c[SLICE_W-1:0];
    assign o_cout = w_c[SLICE_W];

endmodule

// File: rtl/mant_sub_serial.sv
// -----------------------------------------------------------------------------
// mant_sub_serial
//   Byte-serial magnitude subtractor: computes |a-b|, sign of a-b and a zero
//   flag, one 8-bit slice per cycle through a single CLA slice.
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      a/b valid
//   in_ready   out  1      operands accepted (high only in IDLE)
//   a, b       in   WIDTH  unsigned minuend / subtrahend
//   out_valid  out  1      result valid, held until out_ready
//   out_ready  in   1      consumer takes result
//   diff       out  WIDTH  |a-b|
//   neg        out  1      a < b
//   zero       out  1      a == b
//   dbg_state  out  2      current FSM state, for observation only
// Handshake: a transfer happens on a rising edge where valid and ready are
//   both high; the producer holds its data steady while valid && !ready.
// -----------------------------------------------------------------------------
module mant_sub_serial
    import mant_sub_serial_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             neg,
    output logic             zero,
    output logic [1:0]       dbg_state
);

    localparam int N     = WIDTH / SLICE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int OFS_W = CNT_W + SLICE_SH;

    state_t             r_state;
    state_t             w_state_n;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_d;
    logic               r_carry;
    logic               r_neg;
    logic               r_zero;
    logic               r_out_valid;

    logic [OFS_W-1:0]   w_ofs;
    logic               w_last;
    logic [SLICE_W-1:0] w_op_a;
    logic [SLICE_W-1:0] w_op_b;
    logic [SLICE_W-1:0] w_sum;
    logic               w_cout;

    assign w_ofs  = {r_cnt, {SLICE_SH{1'b0}}};
    assign w_last = (r_cnt == CNT_W'(N - 1));

    // SUB: a[k] + ~b[k] + carry.  NEG: 0 + ~d[k] + carry (two's-complement
    // negate of the wrapped difference, giving b-a).
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        if (r_state == SUB) begin
            w_op_a = r_a[w_ofs +: SLICE_W];
            w_op_b = ~r_b[w_ofs +: SLICE_W];
        end else if (r_state == NEG) begin
            w_op_b = ~r_d[w_ofs +: SLICE_W];
        end
    end

    mant_sub_serial_cla8 u_cla8 (
        .i_a    (w_op_a),
        .i_b    (w_op_b),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Next-state logic
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE: if (in_valid) w_state_n = SUB;
            SUB:  if (w_last)   w_state_n = w_cout ? DONE : NEG;
            NEG:  if (w_last)   w_state_n = DONE;
            DONE: if (r_out_valid && out_ready) w_state_n = IDLE;
            default:            w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_n;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_d         <= '0;
            r_carry     <= 1'b0;
            r_neg       <= 1'b0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= 1'b1;
                        r_cnt   <= '0;
                        r_neg   <= 1'b0;
                        r_zero  <= 1'b0;
                    end
                end
                SUB: begin
                    r_d[w_ofs +: SLICE_W] <= w_sum;
                    r_carry               <= w_cout;
                    if (w_last) begin
                        r_cnt <= '0;
                        // No carry out of the top slice means a borrow: a < b.
                        if (!w_cout) begin
                            r_neg   <= 1'b1;
                            r_carry <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                NEG: begin
                    r_d[w_ofs +: SLICE_W] <= w_sum;
                    r_carry               <= w_cout;
                    if (w_last) r_cnt <= '0;
                    else        r_cnt <= r_cnt + CNT_W'(1);
                end
                DONE: begin
                    // First DONE cycle registers zero and raises out_valid;
                    // afterwards everything holds until the consumer accepts.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_zero      <= (r_d == '0);
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign diff      = r_d;
    assign neg       = r_neg;
    assign zero      = r_zero;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mant_sub_serial.sv
module tb_mant_sub_serial;

  localparam int W = 24;
  localparam int NS = W / 8;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  diff;
  logic          neg;
  logic          zero;
  logic [1:0]    dbg_state;

  int n_checks;
  int n_fail;

  // scoreboard entries: {neg, zero, diff}
  logic [W+1:0] exp_q[$];

  mant_sub_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .neg       (neg),
    .zero      (zero),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference: plain integer arithmetic on the operands
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb);
    longint da;
    longint db;
    longint d;
    logic   n;
    logic   z;
    da = longint'(ma);
    db = longint'(mb);
    n  = (da < db);
    z  = (da == db);
    d  = n ? (db - da) : (da - db);
    return {n, z, d[W-1:0]};
  endfunction

  // Runs one operation. Called just after a rising edge (#1).
  // stall: cycles out_ready is held low once out_valid is up.
  // poke : drive a competing in_valid during the stall window.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input int stall, input bit poke, input string tag);
    int t;
    int lat;
    int exp_lat;
    logic [W+1:0] e;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check_val({tag, "_rdy_to"}, 32'(t < 50), 32'd1);
    a         = ta;
    b         = tb;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    exp_q.push_back(model(ta, tb));
    exp_lat   = (ta >= tb) ? NS + 1 : 2 * NS + 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    lat      = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    e = exp_q.pop_front();
    check_val({tag, "_diff"}, 32'(diff), 32'(e[W-1:0]));
    check_val({tag, "_neg"},  32'(neg),  32'(e[W+1]));
    check_val({tag, "_zero"}, 32'(zero), 32'(e[W]));
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        in_valid = 1'b1;
        a        = 24'h123456;
        b        = 24'h000001;
      end
      @(posedge clk); #1;
      if (poke || i == stall - 1) begin
        check_val({tag, "_hold_ov"},   32'(out_valid), 32'd1);
        check_val({tag, "_hold_rdy"},  32'(in_ready),  32'd0);
        check_val({tag, "_hold_diff"}, 32'(diff),      32'(e[W-1:0]));
        check_val({tag, "_hold_neg"},  32'(neg),       32'(e[W+1]));
        check_val({tag, "_hold_zero"}, 32'(zero),      32'(e[W]));
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_val({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
    check_val({tag, "_idle"},    32'(in_ready),  32'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    rst       = 1'b1;
    #1;
    check_val("rst_in_ready",  32'(in_ready),  32'd1);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_diff",      32'(diff),      32'd0);
    check_val("rst_neg",       32'(neg),       32'd0);
    check_val("rst_zero",      32'(zero),      32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // directed cases
    run_op(24'h000005, 24'h000003, 0, 1'b0, "t1");
    run_op(24'h000003, 24'h000005, 2, 1'b0, "t2");
    run_op(24'h7FFFFF, 24'h7FFFFF, 0, 1'b0, "t3_eq");
    run_op(24'h000100, 24'h0000FF, 1, 1'b0, "t3_brw");
    run_op(24'h000000, 24'hFFFFFF, 0, 1'b0, "t4_min");
    run_op(24'hFFFFFF, 24'h000000, 0, 1'b0, "t4_max");
    run_op(24'h0000FF, 24'h000100, 0, 1'b0, "t4_nbrw");
    run_op(24'h00AB00, 24'h00AB01, 10, 1'b1, "t5_stall");

    // reset in the middle of SUB (slice 1)
    a        = 24'h00F00F;
    b        = 24'h000001;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_val("t6_rst_ov",   32'(out_valid), 32'd0);
    check_val("t6_rst_rdy",  32'(in_ready),  32'd1);
    check_val("t6_rst_diff", 32'(diff),      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(24'd9, 24'd4, 0, 1'b0, "t6_after");

    // random back-to-back traffic with random stalls
    for (int k = 0; k < 2000; k++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      case ($urandom_range(0, 7))
        0:       begin ra = W'($urandom); rb = ra; end
        1:       begin ra = W'($urandom_range(0, 255)); rb = W'($urandom_range(0, 255)); end
        default: begin ra = W'($urandom); rb = W'($urandom); end
      endcase
      run_op(ra, rb, $urandom_range(0, 3), 1'b0, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
